// File: rtl/icache_miss_ctrl_pkg.sv
// Shared constants for the I-cache miss controller: default sizes, derived
// width helpers and the FSM state encodings.
package icache_miss_ctrl_pkg;

  localparam int WORD_BITS_DEF   = 32;
  localparam int BLOCK_WORDS_DEF = 4;
  localparam int ADDR_BITS_DEF   = 32;

  localparam int ST_BITS = 3;
  localparam logic [ST_BITS-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_BITS-1:0] ST_REQ    = 3'd1;
  localparam logic [ST_BITS-1:0] ST_FILL   = 3'd2;
  localparam logic [ST_BITS-1:0] ST_WRITE  = 3'd3;
  localparam logic [ST_BITS-1:0] ST_REPLAY = 3'd4;

  // Byte offset width inside a block of 32-bit-addressed words.
  function automatic int ofs_bits(input int block_words);
    return $clog2(block_words) + 2;
  endfunction

endpackage

// File: rtl/icache_miss_ctrl_refill_buf.sv
// Refill buffer: collects one block from memory, one word per beat, in
// word order. The beat counter wraps back to 0 after the last word.
module icache_refill_buf
  import icache_miss_ctrl_pkg::*;
#(
  parameter int WORD_BITS   = WORD_BITS_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             wr_en,
  input  logic [WORD_BITS-1:0]             wdata,
  output logic [BLOCK_WORDS*WORD_BITS-1:0] block,
  output logic                             last_beat
);

  localparam int CNT_BITS = $clog2(BLOCK_WORDS);

  logic [CNT_BITS-1:0]                     cnt_q, cnt_d;
  logic [BLOCK_WORDS-1:0][WORD_BITS-1:0]   buf_q, buf_d;

  // Next-state: clear restarts the block, each beat fills the next word.
  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clear) begin
      cnt_d = '0;
      buf_d = '0;
    end else if (wr_en) begin
      buf_d[cnt_q] = wdata;
      cnt_d        = cnt_q + CNT_BITS'(1);
    end
  end

  // Counter and block storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  assign block     = buf_q;
  assign last_beat = (cnt_q == CNT_BITS'(BLOCK_WORDS - 1));

endmodule

// File: rtl/icache_miss_ctrl.sv
// I-cache miss controller: same-cycle lookup for fetch, and on a miss a
// block refill from memory, array write, then a replayed lookup.
module icache_miss_ctrl
  import icache_miss_ctrl_pkg::*;
#(
  parameter int WORD_BITS   = WORD_BITS_DEF,
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      if_req,
  input  logic [ADDR_BITS-1:0]                      if_addr,
  output logic [WORD_BITS-1:0]                      if_instr,
  output logic                                      if_stall,
  output logic                                      arr_ren,
  output logic                                      arr_wen,
  output logic [ADDR_BITS-ofs_bits(BLOCK_WORDS)-1:0] arr_blk_addr,
  output logic [BLOCK_WORDS*WORD_BITS-1:0]          arr_wdata,
  input  logic                                      arr_hit,
  input  logic [BLOCK_WORDS*WORD_BITS-1:0]          arr_rdata,
  output logic                                      mem_req,
  output logic [ADDR_BITS-ofs_bits(BLOCK_WORDS)-1:0] mem_addr,
  input  logic                                      mem_ack,
  input  logic                                      mem_rvalid,
  input  logic [WORD_BITS-1:0]                      mem_rdata
);

  localparam int OFS_BITS      = ofs_bits(BLOCK_WORDS);
  localparam int BLK_ADDR_BITS = ADDR_BITS - OFS_BITS;
  localparam int SEL_BITS      = OFS_BITS - 2;

  logic [ST_BITS-1:0]                     state_q, state_d;
  logic [BLK_ADDR_BITS-1:0]               lat_q, lat_d;

  logic [BLK_ADDR_BITS-1:0]               if_blk;
  logic [SEL_BITS-1:0]                    if_sel;
  logic [BLOCK_WORDS-1:0][WORD_BITS-1:0]  rd_words;
  logic [BLOCK_WORDS*WORD_BITS-1:0]       buf_block;
  logic                                   buf_last, buf_clear, buf_wr;
  logic                                   idle_lookup;
  logic                                   ren_c, wen_c, req_c, stall_c;
  logic [BLK_ADDR_BITS-1:0]               blk_c;
  logic [WORD_BITS-1:0]                   instr_c;
  logic                                   unused_addr_lsb;

  assign if_blk          = if_addr[ADDR_BITS-1:OFS_BITS];
  assign if_sel          = if_addr[OFS_BITS-1:2];
  assign rd_words        = arr_rdata;
  assign unused_addr_lsb = ^if_addr[1:0];

  icache_refill_buf #(
    .WORD_BITS  (WORD_BITS),
    .BLOCK_WORDS(BLOCK_WORDS)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (buf_clear),
    .wr_en    (buf_wr),
    .wdata    (mem_rdata),
    .block    (buf_block),
    .last_beat(buf_last)
  );

  // FSM next-state and raw output decode. REPLAY on a redirected (or absent)
  // fetch falls back to a normal IDLE lookup in the same cycle.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    ren_c       = 1'b0;
    wen_c       = 1'b0;
    req_c       = 1'b0;
    stall_c     = 1'b0;
    blk_c       = '0;
    instr_c     = '0;
    buf_clear   = 1'b0;
    buf_wr      = 1'b0;
    idle_lookup = 1'b0;
    case (state_q)
      ST_REQ: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (mem_ack) begin
          state_d   = ST_FILL;
          buf_clear = 1'b1;
        end
      end
      ST_FILL: begin
        stall_c = 1'b1;
        buf_wr  = mem_rvalid;
        if (mem_rvalid && buf_last) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        stall_c = 1'b1;
        wen_c   = 1'b1;
        blk_c   = lat_q;
        state_d = ST_REPLAY;
      end
      ST_REPLAY: begin
        if (if_req && (if_blk == lat_q)) begin
          ren_c = 1'b1;
          blk_c = lat_q;
          if (arr_hit) begin
            instr_c = rd_words[if_sel];
            state_d = ST_IDLE;
          end else begin
            // Block just written but not found: refetch it.
            stall_c = 1'b1;
            state_d = ST_REQ;
          end
        end else begin
          idle_lookup = 1'b1;
        end
      end
      default: idle_lookup = 1'b1;
    endcase

    if (idle_lookup) begin
      ren_c   = if_req;
      blk_c   = if_blk;
      state_d = ST_IDLE;
      if (if_req) begin
        if (arr_hit) begin
          instr_c = rd_words[if_sel];
        end else begin
          stall_c = 1'b1;
          lat_d   = if_blk;
          state_d = ST_REQ;
        end
      end
    end
  end

  // State and latched miss address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Outputs are forced quiet while reset is asserted; stall mirrors the
  // request so fetch holds.
  assign arr_ren      = rst & ren_c;
  assign arr_wen      = rst & wen_c;
  assign arr_blk_addr = rst ? blk_c : '0;
  assign arr_wdata    = (rst && wen_c) ? buf_block : '0;
  assign mem_req      = rst & req_c;
  assign mem_addr     = (rst && req_c) ? lat_q : '0;
  assign if_instr     = (rst && if_req && !stall_c) ? instr_c : '0;
  assign if_stall     = rst ? stall_c : if_req;

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Scoreboard bench for icache_miss_ctrl with a behavioural array and memory.
module tb_icache_miss_ctrl;
  import icache_miss_ctrl_pkg::*;

  localparam int WB  = 32;
  localparam int BW  = 4;
  localparam int AB  = 32;
  localparam int BAB = 28;

  logic clk = 1'b0;
  logic rst;
  logic if_req;
  logic [AB-1:0] if_addr;
  logic [WB-1:0] if_instr;
  logic if_stall, arr_ren, arr_wen, arr_hit;
  logic [BAB-1:0] arr_blk_addr, mem_addr;
  logic [BW*WB-1:0] arr_wdata, arr_rdata;
  logic mem_req, mem_ack, mem_rvalid;
  logic [WB-1:0] mem_rdata;

  icache_miss_ctrl #(.WORD_BITS(WB), .BLOCK_WORDS(BW), .ADDR_BITS(AB)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_instr(if_instr),
    .if_stall(if_stall), .arr_ren(arr_ren), .arr_wen(arr_wen), .arr_blk_addr(arr_blk_addr),
    .arr_wdata(arr_wdata), .arr_hit(arr_hit), .arr_rdata(arr_rdata), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [BW*WB-1:0] act, input logic [BW*WB-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [WB-1:0] beat_data(input logic [BAB-1:0] blk, input int i);
    return {blk[15:0], 12'hB00, 4'(i)};
  endfunction

  function automatic logic [BW*WB-1:0] block_data(input logic [BAB-1:0] blk);
    logic [BW*WB-1:0] r;
    r = '0;
    for (int i = 0; i < BW; i++) r[i*WB +: WB] = beat_data(blk, i);
    return r;
  endfunction

  // Array model: 256 direct-mapped entries, full block address as tag.
  logic            m_vld [256] = '{default: 1'b0};
  logic [BAB-1:0]  m_tag [256];
  logic [BW*WB-1:0] m_dat [256];

  always @(posedge clk)
    if (arr_wen) begin
      m_vld[arr_blk_addr[7:0]] <= 1'b1;
      m_tag[arr_blk_addr[7:0]] <= arr_blk_addr;
      m_dat[arr_blk_addr[7:0]] <= arr_wdata;
    end

  always_comb begin
    arr_hit   = arr_ren && m_vld[arr_blk_addr[7:0]] && (m_tag[arr_blk_addr[7:0]] == arr_blk_addr);
    arr_rdata = m_dat[arr_blk_addr[7:0]];
  end

  // Memory responder controls (written by the main process only).
  int ack_dly   = 0;
  int beat_gap  = 1;
  int stray_req = 0;
  // Responder status (written by the responder only).
  int beats_sent    = 0;
  int last_beat_cyc = 0;

  initial begin
    int rsp_state, req_seen, gcnt, bidx, stray_done;
    logic [BAB-1:0] rs_blk;
    rsp_state = 0; req_seen = 0; gcnt = 0; bidx = 0; stray_done = 0; rs_blk = '0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (!rst) begin
        rsp_state = 0;
        continue;
      end
      if (stray_done < stray_req) begin
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hDEAD_0000 + 32'(stray_done);
        stray_done++;
        continue;
      end
      if (rsp_state == 0 && mem_req) begin
        rs_blk = mem_addr; req_seen = 0; rsp_state = 1;
      end
      if (rsp_state == 1) begin
        req_seen++;
        if (req_seen > ack_dly) begin
          mem_ack = 1'b1; rsp_state = 2; bidx = 0; gcnt = 0;
        end
      end else if (rsp_state == 2) begin
        if (gcnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = beat_data(rs_blk, bidx);
          beats_sent++;
          last_beat_cyc = cyc;
          bidx++;
          gcnt = beat_gap - 1;
          if (bidx == BW) rsp_state = 0;
        end else begin
          gcnt--;
        end
      end
    end
  end

  // Scoreboards.
  typedef struct { logic [WB-1:0] instr; bit miss; } exp_t;
  exp_t           exp_q[$];
  logic [BAB-1:0] exp_mem[$];

  int wen_cnt = 0;
  int req_rises = 0;
  int last_req_len = 0;

  // Monitor: per-cycle assertions, instruction and memory-request scoreboards.
  initial begin
    int req_len;
    logic req_prev;
    logic [BAB-1:0] last_req_addr;
    exp_t e;
    req_len = 0; req_prev = 1'b0; last_req_addr = '0;
    forever begin
      @(negedge clk);
      chk("ren_wen_excl", 128'(arr_ren && arr_wen), 128'(0));
      if (mem_req) chk("mem_req_in_req", 128'(dut.state_q), 128'(ST_REQ));
      if (rst && if_req && !if_stall) begin
        chk("unstall_implies_hit", 128'(arr_hit), 128'(1));
        if (exp_q.size() == 0) begin
          chk("unexpected_instr", 128'(if_instr), 128'(0));
          chk("unexpected_instr_cnt", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("if_instr", 128'(if_instr), 128'(e.instr));
          if (e.miss) chk("miss_stall_end", 128'(cyc - last_beat_cyc), 128'(2));
        end
      end
      if (mem_req && !req_prev) begin
        req_rises++;
        if (exp_mem.size() == 0) begin
          chk("unexpected_mem_req", 128'(mem_addr), 128'(0));
          chk("unexpected_mem_req_cnt", 128'(1), 128'(0));
        end else begin
          last_req_addr = exp_mem.pop_front();
          chk("mem_addr", 128'(mem_addr), 128'(last_req_addr));
        end
      end
      if (mem_req) req_len++;
      else if (req_prev) begin
        last_req_len = req_len;
        req_len = 0;
      end
      req_prev = mem_req;
      if (arr_wen) begin
        wen_cnt++;
        chk("arr_blk_addr_wr", 128'(arr_blk_addr), 128'(last_req_addr));
        chk("arr_wdata", arr_wdata, block_data(arr_blk_addr));
      end
    end
  end

  task automatic wait_release(input string name);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!if_stall) begin ok = 1'b1; break; end
    end
    if (!ok) chk({name, "_timeout"}, 128'(if_stall), 128'(0));
    @(posedge clk); #1;
  endtask

  task automatic fetch(input logic [AB-1:0] a, input bit miss);
    exp_t e;
    e.instr = beat_data(a[AB-1:4], int'(a[3:2]));
    e.miss  = miss;
    exp_q.push_back(e);
    if (miss) exp_mem.push_back(a[AB-1:4]);
    if_req  = 1'b1;
    if_addr = a;
    wait_release("fetch");
  endtask

  task automatic wait_beats(input int target);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (beats_sent >= target) begin ok = 1'b1; break; end
    end
    if (!ok) chk("beat_wait_timeout", 128'(beats_sent), 128'(target));
  endtask

  initial begin
    int c0, r0, w0, b0;
    rst = 1'b0; if_req = 1'b0; if_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_arr_ren", 128'(arr_ren), 128'(0));
    chk("rst_arr_wen", 128'(arr_wen), 128'(0));
    chk("rst_mem_req", 128'(mem_req), 128'(0));
    chk("rst_if_instr", 128'(if_instr), 128'(0));
    chk("rst_if_stall_lo", 128'(if_stall), 128'(0));
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    chk("rst_if_stall_hi", 128'(if_stall), 128'(1));
    chk("rst_arr_ren_req", 128'(arr_ren), 128'(0));
    if_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #1;

    // 1: cold miss on 0x100
    fetch(32'h100, 1'b1);
    if_req = 1'b0;
    chk("t1_wen_cnt", 128'(wen_cnt), 128'(1));
    chk("t1_req_len", 128'(last_req_len), 128'(1));

    // 2: hit stream, one per cycle
    r0 = req_rises; c0 = cyc;
    fetch(32'h100, 1'b0);
    fetch(32'h104, 1'b0);
    fetch(32'h108, 1'b0);
    fetch(32'h10C, 1'b0);
    chk("t2_cycles", 128'(cyc - c0), 128'(4));
    if_req = 1'b0;
    chk("t2_no_mem_req", 128'(req_rises), 128'(r0));

    // 3: slow ack and spaced beats
    ack_dly = 5; beat_gap = 2;
    fetch(32'h504, 1'b1);
    if_req = 1'b0;
    chk("t3_req_len", 128'(last_req_len), 128'(6));
    ack_dly = 0; beat_gap = 1;

    // 4: reset during beat 2 of a refill
    w0 = wen_cnt; b0 = beats_sent;
    exp_mem.push_back(28'h30);
    if_req = 1'b1; if_addr = 32'h308;
    wait_beats(b0 + 3);
    rst = 1'b0;
    #1;
    chk("t4_arr_ren", 128'(arr_ren), 128'(0));
    chk("t4_arr_wen", 128'(arr_wen), 128'(0));
    chk("t4_mem_req", 128'(mem_req), 128'(0));
    chk("t4_mem_addr", 128'(mem_addr), 128'(0));
    chk("t4_blk_addr", 128'(arr_blk_addr), 128'(0));
    chk("t4_if_instr", 128'(if_instr), 128'(0));
    chk("t4_if_stall", 128'(if_stall), 128'(1));
    if_req = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    r0 = req_rises;
    stray_req = 3;
    repeat (6) @(posedge clk);
    #1;
    chk("t4_stray_no_req", 128'(req_rises), 128'(r0));
    chk("t4_stray_no_wen", 128'(wen_cnt), 128'(w0));
    fetch(32'h308, 1'b1);
    if_req = 1'b0;
    chk("t4_wen_cnt", 128'(wen_cnt), 128'(w0 + 1));

    // 5: redirect to 0x200 during FILL
    w0 = wen_cnt; b0 = beats_sent;
    exp_mem.push_back(28'h40);
    if_req = 1'b1; if_addr = 32'h400;
    wait_beats(b0 + 1);
    @(posedge clk); #1;
    begin
      exp_t e;
      e.instr = beat_data(28'h20, 2);
      e.miss  = 1'b1;
      exp_q.push_back(e);
      exp_mem.push_back(28'h20);
    end
    if_addr = 32'h208;
    wait_release("redirect");
    if_req = 1'b0;
    chk("t5_wen_cnt", 128'(wen_cnt), 128'(w0 + 2));
    fetch(32'h40C, 1'b0);
    if_req = 1'b0;

    repeat (4) @(posedge clk);
    chk("exp_q_empty", 128'(exp_q.size()), 128'(0));
    chk("exp_mem_empty", 128'(exp_mem.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
